// File: rtl/csa_accum.sv
// Carry-save packet accumulator: operands are absorbed into a redundant sum/carry pair in one
// cycle each, and the final pair is resolved by a CHUNK-wide ripple adder over N cycles.
module csa_accum #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int N  = ACC_W / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] s_q, s_d;
    logic [ACC_W-1:0] c_q, c_d;
    logic [ACC_W-1:0] r_q, r_d;
    logic             ovf_q, ovf_d;
    logic             cy_q, cy_d;
    logic [KW-1:0]    k_q, k_d;

    logic [ACC_W-1:0] x_s;
    logic [ACC_W-1:0] maj_s;
    logic [CHUNK:0]   slice_sum_s;

    function automatic logic [ACC_W-1:0] maj3(input logic [ACC_W-1:0] a,
                                              input logic [ACC_W-1:0] b,
                                              input logic [ACC_W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCUM;
            s_q     <= '0;
            c_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            cy_q    <= 1'b0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            c_q     <= c_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            cy_q    <= cy_d;
            k_q     <= k_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid && in_last) begin
                    state_d = ST_RESOLVE;
                end else begin
                    state_d = ST_ACCUM;
                end
            end
            ST_RESOLVE: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // Carry-save absorption and sliced carry resolution
    always_comb begin
        x_s         = ACC_W'(in_data);
        maj_s       = maj3(s_q, c_q, x_s);
        slice_sum_s = {1'b0, s_q[int'(k_q)*CHUNK +: CHUNK]}
                    + {1'b0, c_q[int'(k_q)*CHUNK +: CHUNK]}
                    + (CHUNK+1)'(cy_q);
        s_d   = s_q;
        c_d   = c_q;
        r_d   = r_q;
        ovf_d = ovf_q;
        cy_d  = cy_q;
        k_d   = k_q;
        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    s_d   = s_q ^ c_q ^ x_s;
                    c_d   = maj_s << 1;
                    // The majority bit shifted off the top is a lost 2^ACC_W weight.
                    ovf_d = ovf_q | maj_s[ACC_W-1];
                    cy_d  = 1'b0;
                    k_d   = '0;
                end else begin
                    s_d = s_q;
                end
            end
            ST_RESOLVE: begin
                r_d[int'(k_q)*CHUNK +: CHUNK] = slice_sum_s[CHUNK-1:0];
                cy_d = slice_sum_s[CHUNK];
                if (k_q == K_LAST) begin
                    ovf_d = ovf_q | slice_sum_s[CHUNK];
                    k_d   = '0;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    s_d   = '0;
                    c_d   = '0;
                    r_d   = '0;
                    ovf_d = 1'b0;
                    cy_d  = 1'b0;
                    k_d   = '0;
                end else begin
                    r_d = r_q;
                end
            end
            default: begin
                s_d   = '0;
                c_d   = '0;
                r_d   = '0;
                ovf_d = 1'b0;
                cy_d  = 1'b0;
                k_d   = '0;
            end
        endcase
    end

    // Output decode straight from registered state
    always_comb begin
        in_ready  = (state_q == ST_ACCUM);
        out_valid = (state_q == ST_DONE);
        if (state_q == ST_DONE) begin
            out_data = r_q;
            out_ovf  = ovf_q;
        end else begin
            out_data = '0;
            out_ovf  = 1'b0;
        end
    end

endmodule
